register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Parametrised successor to the single 16-bit register: a bank of NUM_REGS registers, each WIDTH bits wide.
- Supports per-cycle write, increment, decrement and clear on one addressed register, with wrap or saturate arithmetic.
- Provides two combinational read ports and registered status flags.
- Holds per-core program counter, address and general-purpose registers in the multi-core processor datapath.

Parameters:
WIDTH, 16, bit width of each register (>=2)
NUM_REGS, 8, number of registers (power of two, >=2)
ADDR_W, 3, address width = log2(NUM_REGS)
SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones/zero
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  input  1  rising-edge clock
rst_en  input  1  asynchronous active-high reset
op_addr  input  ADDR_W  register targeted by this cycle's operation
clr_en  input  1  synchronous clear of op_addr register to 0
write_en  input  1  load data_in into op_addr register
inc_en  input  1  op_addr register += 1
dec_en  input  1  op_addr register -= 1
data_in  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
data_out_a  output  WIDTH  contents of register rd_addr_a
data_out_b  output  WIDTH  contents of register rd_addr_b
zero_flag  output  1  result of last executed op was 0
carry_flag  output  1  last inc/dec wrapped (SATURATE=0) or was clamped (SATURATE=1)
op_done  output  1  pulses 1 cycle after any op executes

Behaviour:
- Reset (rst_en=1, asynchronous, immediate):
  - all registers = RESET_VAL.
  - zero_flag = (RESET_VAL==0); carry_flag = 0; op_done = 0.
  - Reset overrides any op in flight; the first op executes at the first rising edge with rst_en=0.
- One op per cycle, fixed priority: clr_en > write_en > inc_en > dec_en.
  - Lower-priority enables asserted alongside a higher one are ignored that cycle, with no side effects.
- All ops update the op_addr register at the rising edge. No other register changes.
- Arithmetic is unsigned, WIDTH bits.
  - SATURATE=0: all-ones+1 -> 0, carry_flag=1; 0-1 -> all-ones, carry_flag=1.
  - SATURATE=1: all-ones+1 stays all-ones, carry_flag=1; 0-1 stays 0, carry_flag=1.
  - Otherwise carry_flag=0.
- Flags are registered and updated on the same edge as the register, reflecting that op's result:
  - zero_flag = (new value == 0).
  - clr and write set carry_flag = 0.
  - Flags hold their value in cycles with no op.
- op_done = 1 for exactly one cycle after any executed op; 0 otherwise. Back-to-back ops keep op_done high continuously.
- Read ports are combinational from register contents; both ports may address the same register.
- No bypass: a read of the register being modified shows the old value until the edge, then the new value.
- Enable inputs are sampled only at rising edges; mid-cycle changes have no effect.
- op_addr is always in range because NUM_REGS = 2^ADDR_W.

Test Plan:
1. Reset then write: rst_en pulse; write_en=1, op_addr=2, data_in=10 -> after edge data_out_a(rd_addr_a=2)=10, other registers 0, zero_flag=0, op_done=1 for one cycle.
2. Increment/priority: reg2=10; inc_en=1 for 1 cycle -> 11; then write_en=1, inc_en=1, data_in=15 -> 15 (inc ignored); clr_en+write_en -> 0, zero_flag=1.
3. Wrap (SATURATE=0): write reg5=16'hFFFF, inc_en -> 0, zero_flag=1, carry_flag=1; dec_en -> 16'hFFFF, carry_flag=1, zero_flag=0.
4. Saturate (SATURATE=1 instance): write 16'hFFFF, inc -> 16'hFFFF, carry_flag=1; write 0, dec -> 0, carry_flag=1, zero_flag=1; write 5, dec -> 4, carry_flag=0.
5. Dual read, no bypass: write reg1=7, reg3=9; rd_addr_a=1, rd_addr_b=3 -> 7, 9; inc reg1 with rd_addr_a=1 -> shows 7 before the edge, 8 after.
6. Async reset mid-op: inc_en held high on reg4 for 5 cycles, assert rst_en between edges -> all outputs drop to reset values immediately without waiting for clk; after release, counting resumes from RESET_VAL.

Source files
------------

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers with one write/inc/dec/clear op per cycle,
// two combinational read ports and registered zero/carry/op_done status.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int SATURATE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_en,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic              clr_en,
  input  logic              write_en,
  input  logic              inc_en,
  input  logic              dec_en,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              op_done
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] new_val;
  logic             new_carry;
  logic             op_valid;

  assign cur_val  = regs[op_addr];
  assign op_valid = clr_en | write_en | inc_en | dec_en;

  // Priority clr > write > inc > dec; the overflow/underflow boundary
  // either wraps or holds depending on SATURATE, and flags carry in both.
  always_comb begin
    new_val   = cur_val;
    new_carry = 1'b0;
    if (clr_en) begin
      new_val = '0;
    end else if (write_en) begin
      new_val = data_in;
    end else if (inc_en) begin
      if (cur_val == ALL_ONES) begin
        new_carry = 1'b1;
        new_val   = (SATURATE != 0) ? ALL_ONES : '0;
      end else begin
        new_val = cur_val + ONE;
      end
    end else if (dec_en) begin
      if (cur_val == '0) begin
        new_carry = 1'b1;
        new_val   = (SATURATE != 0) ? '0 : ALL_ONES;
      end else begin
        new_val = cur_val - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
      zero_flag  <= (RESET_VAL == '0);
      carry_flag <= 1'b0;
      op_done    <= 1'b0;
    end else begin
      op_done <= op_valid;
      if (op_valid) begin
        regs[op_addr] <= new_val;
        zero_flag     <= (new_val == '0);
        carry_flag    <= new_carry;
      end
    end
  end

  // No bypass: reads see the stored contents until the op's edge.
  assign data_out_a = regs[rd_addr_a];
  assign data_out_b = regs[rd_addr_b];

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: wrap and saturate instances share stimulus and
// are compared against an arithmetic reference model plus fixed vectors.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_en;
  logic [2:0]  op_addr;
  logic        clr_en, write_en, inc_en, dec_en;
  logic [15:0] data_in;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] out_a_w, out_b_w, out_a_s, out_b_s;
  logic        z_w, c_w, d_w, z_s, c_s, d_s;

  int total = 0;
  int bad = 0;

  // reference model: index 0 = wrap instance, 1 = saturate instance
  logic [15:0] m_reg [2][8];
  logic        m_z [2];
  logic        m_c [2];
  logic        m_d [2];

  always #5 clk = ~clk;

  register_bank #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .SATURATE(0), .RESET_VAL(16'h0)) dut_w (
    .clk(clk), .rst_en(rst_en), .op_addr(op_addr), .clr_en(clr_en), .write_en(write_en),
    .inc_en(inc_en), .dec_en(dec_en), .data_in(data_in), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .data_out_a(out_a_w), .data_out_b(out_b_w),
    .zero_flag(z_w), .carry_flag(c_w), .op_done(d_w)
  );

  register_bank #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .SATURATE(1), .RESET_VAL(16'h0)) dut_s (
    .clk(clk), .rst_en(rst_en), .op_addr(op_addr), .clr_en(clr_en), .write_en(write_en),
    .inc_en(inc_en), .dec_en(dec_en), .data_in(data_in), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .data_out_a(out_a_s), .data_out_b(out_b_s),
    .zero_flag(z_s), .carry_flag(c_s), .op_done(d_s)
  );

  typedef struct {
    logic        clr, wr, inc, dec;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  rda;
    logic [15:0] exp_a;
    logic        exp_z, exp_c, exp_d;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 8; r++) m_reg[s][r] = 16'h0;
      m_z[s] = 1'b1;
      m_c[s] = 1'b0;
      m_d[s] = 1'b0;
    end
  endtask

  // Evaluated with the inputs present at the rising edge.
  task automatic model_edge();
    int v;
    bit cy;
    for (int s = 0; s < 2; s++) begin
      m_d[s] = clr_en | write_en | inc_en | dec_en;
      if (m_d[s]) begin
        v  = int'(m_reg[s][op_addr]);
        cy = 1'b0;
        if (clr_en) v = 0;
        else if (write_en) v = int'(data_in);
        else if (inc_en) begin
          v = v + 1;
          if (v > 65535) begin cy = 1'b1; v = (s == 1) ? 65535 : 0; end
        end else begin
          v = v - 1;
          if (v < 0) begin cy = 1'b1; v = (s == 1) ? 0 : 65535; end
        end
        m_reg[s][op_addr] = v[15:0];
        m_z[s] = (v == 0);
        m_c[s] = cy;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " w.out_a"}, out_a_w, m_reg[0][rd_addr_a]);
    chk({tag, " w.out_b"}, out_b_w, m_reg[0][rd_addr_b]);
    chk({tag, " w.zero"}, z_w, m_z[0]);
    chk({tag, " w.carry"}, c_w, m_c[0]);
    chk({tag, " w.done"}, d_w, m_d[0]);
    chk({tag, " s.out_a"}, out_a_s, m_reg[1][rd_addr_a]);
    chk({tag, " s.out_b"}, out_b_s, m_reg[1][rd_addr_b]);
    chk({tag, " s.zero"}, z_s, m_z[1]);
    chk({tag, " s.carry"}, c_s, m_c[1]);
    chk({tag, " s.done"}, d_s, m_d[1]);
  endtask

  task automatic idle_enables();
    clr_en = 0; write_en = 0; inc_en = 0; dec_en = 0;
  endtask

  // Drive one op, clock it in, sample 1 time unit after the edge, then idle.
  task automatic do_op(input logic c, input logic w, input logic i, input logic d,
                       input logic [2:0] a, input logic [15:0] din);
    clr_en = c; write_en = w; inc_en = i; dec_en = d; op_addr = a; data_in = din;
    @(posedge clk);
    model_edge();
    #1;
    idle_enables();
  endtask

  initial begin
    rst_en = 1; op_addr = 0; data_in = 0; rd_addr_a = 0; rd_addr_b = 0;
    idle_enables();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_model("reset");
    chk("reset zero_flag", z_w, 1'b1);
    chk("reset op_done", d_w, 1'b0);
    rst_en = 0;

    // clr wr inc dec addr data rda exp_a z c d
    vecs[0]  = '{0, 1, 0, 0, 3'd2, 16'd10,   3'd2, 16'd10,   0, 0, 1};
    vecs[1]  = '{0, 0, 1, 0, 3'd2, 16'd0,    3'd2, 16'd11,   0, 0, 1};
    vecs[2]  = '{0, 1, 1, 0, 3'd2, 16'd15,   3'd2, 16'd15,   0, 0, 1};
    vecs[3]  = '{1, 1, 0, 0, 3'd2, 16'd99,   3'd2, 16'd0,    1, 0, 1};
    vecs[4]  = '{0, 1, 0, 0, 3'd5, 16'hFFFF, 3'd5, 16'hFFFF, 0, 0, 1};
    vecs[5]  = '{0, 0, 1, 0, 3'd5, 16'd0,    3'd5, 16'h0000, 1, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 3'd5, 16'd0,    3'd5, 16'hFFFF, 0, 1, 1};
    vecs[7]  = '{0, 1, 0, 0, 3'd1, 16'd7,    3'd1, 16'd7,    0, 0, 1};
    vecs[8]  = '{0, 0, 0, 1, 3'd1, 16'd0,    3'd1, 16'd6,    0, 0, 1};
    vecs[9]  = '{0, 0, 1, 1, 3'd1, 16'd0,    3'd1, 16'd7,    0, 0, 1};
    vecs[10] = '{0, 0, 0, 1, 3'd0, 16'd0,    3'd0, 16'hFFFF, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 3'd0, 16'd0,    3'd0, 16'hFFFF, 0, 1, 0};

    for (int i = 0; i < 12; i++) begin
      rd_addr_a = vecs[i].rda;
      rd_addr_b = 3'd2;
      do_op(vecs[i].clr, vecs[i].wr, vecs[i].inc, vecs[i].dec, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d out_a", i), out_a_w, vecs[i].exp_a);
      chk($sformatf("vec%0d zero", i), z_w, vecs[i].exp_z);
      chk($sformatf("vec%0d carry", i), c_w, vecs[i].exp_c);
      chk($sformatf("vec%0d done", i), d_w, vecs[i].exp_d);
      check_model($sformatf("vec%0d", i));
    end

    // saturate boundaries on the SATURATE=1 instance
    rd_addr_a = 3'd6;
    do_op(0, 1, 0, 0, 3'd6, 16'hFFFF);
    do_op(0, 0, 1, 0, 3'd6, 16'h0);
    chk("sat inc value", out_a_s, 16'hFFFF);
    chk("sat inc carry", c_s, 1'b1);
    chk("wrap inc value", out_a_w, 16'h0000);
    do_op(0, 1, 0, 0, 3'd6, 16'h0);
    do_op(0, 0, 0, 1, 3'd6, 16'h0);
    chk("sat dec value", out_a_s, 16'h0000);
    chk("sat dec carry", c_s, 1'b1);
    chk("sat dec zero", z_s, 1'b1);
    do_op(0, 1, 0, 0, 3'd6, 16'd5);
    do_op(0, 0, 0, 1, 3'd6, 16'h0);
    chk("sat dec5 value", out_a_s, 16'd4);
    chk("sat dec5 carry", c_s, 1'b0);
    check_model("sat seq");

    // dual read and no bypass
    do_op(0, 1, 0, 0, 3'd1, 16'd7);
    do_op(0, 1, 0, 0, 3'd3, 16'd9);
    rd_addr_a = 3'd1; rd_addr_b = 3'd3; #1;
    chk("dual read a", out_a_w, 16'd7);
    chk("dual read b", out_b_w, 16'd9);
    rd_addr_b = 3'd1;
    inc_en = 1; op_addr = 3'd1; #1;
    chk("no bypass before edge", out_a_w, 16'd7);
    chk("same reg both ports", out_b_w, 16'd7);
    @(posedge clk);
    model_edge();
    #1;
    idle_enables();
    chk("after edge value", out_a_w, 16'd8);
    check_model("bypass seq");

    // async reset in the middle of a held increment
    rd_addr_a = 3'd4; rd_addr_b = 3'd4;
    inc_en = 1; op_addr = 3'd4;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model_edge();
    end
    #4;
    chk("pre-reset count", out_a_w, 16'd3);
    rst_en = 1;
    model_reset();
    #1;
    chk("async rst value", out_a_w, 16'd0);
    chk("async rst zero", z_w, 1'b1);
    chk("async rst carry", c_w, 1'b0);
    chk("async rst done", d_w, 1'b0);
    check_model("async rst");
    @(posedge clk); #1;
    chk("rst holds over edge", out_a_w, 16'd0);
    rst_en = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    idle_enables();
    chk("resume count", out_a_w, 16'd2);
    check_model("resume");

    // randomized ops against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        2: d = 16'd1;
        default: d = 16'($urandom);
      endcase
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = 3'($urandom_range(0, 7));
      do_op(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
            3'($urandom_range(0, 7)), d);
      check_model("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
